// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - SAP-1 program loader and bus-ownership arbiter.
// Optional LOADER_CHECKSUM_EN: XOR checksum byte after the data, sticky err on mismatch.
module prog_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int CTRL_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              run_req,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              ldr_bus_en,
  output logic [DATA_W-1:0] ldr_bus,
  output logic              mar_load,
  output logic              mem_we,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DAT, S_ADR, S_WR, S_RUN
`ifdef LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          cnt_q;
  logic [DATA_W-1:0]   data_q;
  logic                done_q;
  logic                hs;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   chk_q;
  logic                err_q;
  logic                in_chk;
  assign in_chk = (state_q == S_CHK);
  assign err    = err_q;
`else
  logic                in_chk;
  assign in_chk = 1'b0;
  assign err    = 1'b0;
`endif

  assign in_ready   = (state_q == S_HDR) || (state_q == S_DAT) || in_chk;
  assign hs         = in_valid && in_ready;
  assign busy       = in_ready || (state_q == S_ADR) || (state_q == S_WR);
  assign cpu_rst    = (state_q != S_RUN);
  assign ctrl_out   = (state_q == S_RUN) ? ctrl_in : '0;
  assign halted     = (state_q == S_RUN) && ctrl_in[CTRL_W-1];
  assign mar_load   = (state_q == S_ADR);
  assign mem_we     = (state_q == S_WR);
  assign ldr_bus_en = mar_load || mem_we;
  assign done       = done_q;

  always_comb begin
    ldr_bus = '0;
    if (state_q == S_ADR) ldr_bus = {{(DATA_W-ADDR_W){1'b0}}, addr_q};
    else if (state_q == S_WR) ldr_bus = data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load_req) begin
            state_q <= S_HDR;
`ifdef LOADER_CHECKSUM_EN
            err_q   <= 1'b0;
          end else if (run_req && !err_q) begin
`else
          end else if (run_req) begin
`endif
            state_q <= S_RUN;
          end
        end
        S_HDR: begin
          if (hs) begin
            addr_q  <= in_data[DATA_W-1 -: ADDR_W];
            cnt_q   <= in_data[3:0];
`ifdef LOADER_CHECKSUM_EN
            chk_q   <= in_data;
`endif
            state_q <= S_DAT;
          end
        end
        S_DAT: begin
          if (hs) begin
            data_q  <= in_data;
`ifdef LOADER_CHECKSUM_EN
            chk_q   <= chk_q ^ in_data;
`endif
            state_q <= S_ADR;
          end
        end
        S_ADR: state_q <= S_WR;
        S_WR: begin
          // Address wraps naturally modulo 2^ADDR_W.
          addr_q <= addr_q + ADDR_W'(1);
          if (cnt_q == 4'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_q <= S_CHK;
`else
            done_q  <= 1'b1;
            state_q <= S_IDLE;
`endif
          end else begin
            cnt_q   <= cnt_q - 4'd1;
            state_q <= S_DAT;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (hs) begin
            if (in_data == chk_q) done_q <= 1'b1;
            else                  err_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
`endif
        S_RUN: if (load_req) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
